shift_seq_ctrl: RTL and testbench

- Command-driven sequencer for a WIDTH-bit shift-register datapath with pins load / direction / serial_input / parallel_load / parallel_out.
- That datapath has no enable and shifts on every clock while load=0, so this block holds it by reloading its own value when idle.
- It sequences LOAD, CLEAR, SHIFT-by-N and ROTATE-by-N commands received over a valid/ready handshake.
- Sits between the top-level pin decode and the shift-register instance.

---
 rtl/shift_seq_pkg.sv | 26 ++
 rtl/shift_seq_ctrl_if.sv | 45 ++++
 rtl/shift_seq_cnt.sv | 27 ++
 rtl/shift_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift-register command sequencer.
// Build option: SHIFT_SEQ_ABORT_EN adds the abort/aborted pins.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_SHIFT  = 2'd1,
        OP_ROTATE = 2'd2,
        OP_CLEAR  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    function automatic logic is_shift_op(input op_e op);
        return (op == OP_SHIFT) || (op == OP_ROTATE);
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command handshake plus datapath pins between pin decode, sequencer and shift register.
// Build option: SHIFT_SEQ_ABORT_EN adds abort (in) and aborted (out).
interface shift_seq_ctrl_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_cnt;
    logic [WIDTH-1:0] cmd_data;
    logic             ser_in;
    logic [WIDTH-1:0] sr_q;
    logic             sr_load;
    logic             sr_dir;
    logic             sr_ser;
    logic [WIDTH-1:0] sr_pload;
    logic             busy;
    logic             done;
`ifdef SHIFT_SEQ_ABORT_EN
    logic             abort;
    logic             aborted;
`endif

    // master: pin decode and datapath side; slave: the sequencer
    modport master (
        output cmd_valid, cmd_op, cmd_dir, cmd_cnt, cmd_data, ser_in, sr_q,
`ifdef SHIFT_SEQ_ABORT_EN
        output abort,
        input  aborted,
`endif
        input  cmd_ready, sr_load, sr_dir, sr_ser, sr_pload, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dir, cmd_cnt, cmd_data, ser_in, sr_q,
`ifdef SHIFT_SEQ_ABORT_EN
        input  abort,
        output aborted,
`endif
        output cmd_ready, sr_load, sr_dir, sr_ser, sr_pload, busy, done
    );

endinterface

// File: rtl/shift_seq_cnt.sv
// Loadable down-counter that saturates at zero; o_last flags a count of one.
module shift_seq_cnt #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for an enable-less shift register: LOAD, CLEAR, SHIFT-by-N, ROTATE-by-N.
// Build option: SHIFT_SEQ_ABORT_EN lets abort cut a SHIFT/ROTATE short.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input logic         clk,
    input logic         rst_n,
    shift_seq_ctrl_if.slave bus
);

    state_e           r_state;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    op_e              r_op;
    logic             r_dir;
    logic [WIDTH-1:0] r_data;

    logic             w_accept;
    logic             w_cmd_shift;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_cnt_dec;
    logic             w_last;
    logic             w_abort;

    assign w_accept    = bus.cmd_valid & r_ready;
    assign w_cmd_shift = is_shift_op(op_e'(bus.cmd_op));

    // Counter is cleared in DONE so an aborted run leaves no residue.
    assign w_cnt_load = ((r_state == S_IDLE) && w_accept) || (r_state == S_DONE);
    assign w_cnt_val  = ((r_state == S_IDLE) && w_cmd_shift) ? bus.cmd_cnt : '0;
    assign w_cnt_dec  = (r_state == S_SHIFT);

    shift_seq_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_cnt_load),
        .i_load_val(w_cnt_val),
        .i_dec     (w_cnt_dec),
        .o_last    (w_last)
    );

`ifdef SHIFT_SEQ_ABORT_EN
    logic r_aborted;
    assign w_abort     = bus.abort;
    assign bus.aborted = r_aborted;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_op    <= OP_LOAD;
            r_dir   <= DIR_RIGHT;
            r_data  <= '0;
`ifdef SHIFT_SEQ_ABORT_EN
            r_aborted <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_op    <= op_e'(bus.cmd_op);
                        r_dir   <= bus.cmd_dir;
                        r_data  <= bus.cmd_data;
                        if (!w_cmd_shift) begin
                            r_state <= S_LOAD;
                        end else if (bus.cmd_cnt != '0) begin
                            r_state <= S_SHIFT;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_SHIFT: begin
                    if (w_last || w_abort) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
`ifdef SHIFT_SEQ_ABORT_EN
                        r_aborted <= w_abort;
`endif
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
`ifdef SHIFT_SEQ_ABORT_EN
                    r_aborted <= 1'b0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outside LOAD/SHIFT the datapath reloads its own output so it holds still.
    always_comb begin
        bus.sr_load  = 1'b1;
        bus.sr_pload = bus.sr_q;
        bus.sr_dir   = DIR_RIGHT;
        bus.sr_ser   = 1'b0;
        unique case (r_state)
            S_LOAD: begin
                bus.sr_pload = (r_op == OP_CLEAR) ? '0 : r_data;
            end
            S_SHIFT: begin
                bus.sr_load = 1'b0;
                bus.sr_dir  = r_dir;
                if (r_op == OP_ROTATE) begin
                    bus.sr_ser = (r_dir == DIR_LEFT) ? bus.sr_q[WIDTH-1] : bus.sr_q[0];
                end else begin
                    bus.sr_ser = bus.ser_in;
                end
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed, table-driven bench for shift_seq_ctrl with a 4-bit shift-register model attached.
// Build option: SHIFT_SEQ_ABORT_EN enables the abort sequence.
module tb_shift_seq_ctrl;
    import shift_seq_pkg::*;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    shift_seq_ctrl #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Shift-register datapath: right shifts take serial_input at the MSB.
    logic [WIDTH-1:0] r_dp = '0;
    always_ff @(posedge clk) begin
        if (bus.sr_load)     r_dp <= bus.sr_pload;
        else if (bus.sr_dir) r_dp <= {r_dp[WIDTH-2:0], bus.sr_ser};
        else                 r_dp <= {bus.sr_ser, r_dp[WIDTH-1:1]};
    end
    assign bus.sr_q = r_dp;

    typedef struct {
        op_e              op;
        logic             dir;
        logic [CNT_W-1:0] cnt;
        logic [WIDTH-1:0] data;
        logic             ser;
        logic [WIDTH-1:0] exp_q;
        int               lat;
    } vec_t;

    vec_t vecs[11];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input op_e op, input logic dir, input logic [CNT_W-1:0] cnt,
                         input logic [WIDTH-1:0] data, input logic ser);
        bus.cmd_op   = op;
        bus.cmd_dir  = dir;
        bus.cmd_cnt  = cnt;
        bus.cmd_data = data;
        bus.ser_in   = ser;
    endtask

    // Returns with ok=1 positioned #1 after the accepting edge.
    task automatic accept(input string name, output logic ok);
        int n = 0;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ok = bus.cmd_ready;
        if (!ok) begin
            check({name, "_ready_timeout"}, 32'(bus.cmd_ready), 32'd1);
            bus.cmd_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
        end
    endtask

    // lat = index of the edge after accept at which done is sampled high (0 = never).
    task automatic wait_done(output int lat, output int low);
        lat = 0;
        low = 0;
        for (int k = 1; k <= 40; k++) begin
            if (!bus.cmd_ready) low++;
            if (bus.done) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_cmd(input string name, input vec_t v);
        logic ok;
        int lat, low;
        drive(v.op, v.dir, v.cnt, v.data, v.ser);
        accept(name, ok);
        if (ok) begin
            wait_done(lat, low);
            check({name, "_latency"}, 32'(lat), 32'(v.lat));
            check({name, "_ready_low"}, 32'(low), 32'(v.lat));
            check({name, "_sr_q"}, 32'(bus.sr_q), 32'(v.exp_q));
            @(posedge clk); #1;
            check({name, "_after_done"}, {29'd0, bus.done, bus.busy, bus.cmd_ready}, 32'd1);
        end
    endtask

    initial begin
        logic ok;
        int lat, low, acc_idx;
        logic saw_done;

        vecs[0]  = '{OP_LOAD,   1'b0, 3'd0, 4'b1011, 1'b0, 4'b1011, 2};
        vecs[1]  = '{OP_SHIFT,  1'b0, 3'd2, 4'b0000, 1'b1, 4'b1110, 3};
        vecs[2]  = '{OP_LOAD,   1'b0, 3'd0, 4'b1001, 1'b0, 4'b1001, 2};
        vecs[3]  = '{OP_ROTATE, 1'b1, 3'd3, 4'b0000, 1'b0, 4'b1100, 4};
        vecs[4]  = '{OP_ROTATE, 1'b0, 3'd4, 4'b0000, 1'b1, 4'b1100, 5};
        vecs[5]  = '{OP_SHIFT,  1'b0, 3'd0, 4'b0000, 1'b1, 4'b1100, 1};
        vecs[6]  = '{OP_CLEAR,  1'b0, 3'd0, 4'b1111, 1'b0, 4'b0000, 2};
        vecs[7]  = '{OP_LOAD,   1'b1, 3'd0, 4'b0110, 1'b1, 4'b0110, 2};
        vecs[8]  = '{OP_SHIFT,  1'b1, 3'd1, 4'b0000, 1'b0, 4'b1100, 2};
        vecs[9]  = '{OP_ROTATE, 1'b0, 3'd7, 4'b0000, 1'b0, 4'b1001, 8};
        vecs[10] = '{OP_SHIFT,  1'b1, 3'd3, 4'b0000, 1'b1, 4'b1111, 4};

        bus.cmd_valid = 1'b0;
        drive(OP_LOAD, 1'b0, '0, '0, 1'b0);
`ifdef SHIFT_SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {29'd0, bus.cmd_ready, bus.busy, bus.done}, 32'd0);
        check("reset_state", 32'(dut.r_state), 32'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i]);
        end

        // LOAD then hold through idle cycles.
        run_cmd("hold_load", vecs[0]);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold_%0d", i), 32'(bus.sr_q), 32'hb);
        end

        // cmd_valid held during SHIFT cnt=7: second command waits for the cycle after done.
        drive(OP_SHIFT, 1'b0, 3'd7, 4'b0000, 1'b0);
        accept("b2b_first", ok);
        if (ok) begin
            bus.cmd_valid = 1'b1;
            drive(OP_LOAD, 1'b0, 3'd0, 4'b0101, 1'b0);
            acc_idx = 0;
            for (int k = 1; k <= 20; k++) begin
                if (bus.cmd_ready) begin
                    acc_idx = k;
                    break;
                end
                @(posedge clk); #1;
            end
            check("b2b_accept_edge", 32'(acc_idx), 32'd9);
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            wait_done(lat, low);
            check("b2b_second_latency", 32'(lat), 32'd2);
            check("b2b_second_sr_q", 32'(bus.sr_q), 32'h5);
            @(posedge clk); #1;
            check("b2b_no_third", {30'd0, bus.busy, bus.cmd_ready}, 32'd1);
        end

        // Reset in the middle of a SHIFT.
        drive(OP_SHIFT, 1'b1, 3'd7, 4'b0000, 1'b1);
        accept("rst_mid", ok);
        if (ok) begin
            @(posedge clk);
            @(posedge clk); #1;
            check("rst_mid_in_shift", 32'(bus.busy), 32'd1);
            rst_n = 1'b0;
            #2;
            check("rst_mid_outputs", {29'd0, bus.cmd_ready, bus.busy, bus.done}, 32'd0);
            check("rst_mid_state", 32'(dut.r_state), 32'(S_IDLE));
            @(negedge clk);
            rst_n = 1'b1;
            saw_done = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #1;
                if (bus.done || bus.busy) saw_done = 1'b1;
            end
            check("rst_mid_no_done", 32'(saw_done), 32'd0);
            check("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);
            run_cmd("rst_recover", vecs[2]);
        end

`ifdef SHIFT_SEQ_ABORT_EN
        // Abort in the second SHIFT cycle of cnt=5: two shifts land.
        run_cmd("abort_clear", vecs[6]);
        drive(OP_SHIFT, 1'b1, 3'd5, 4'b0000, 1'b1);
        accept("abort", ok);
        if (ok) begin
            @(posedge clk); #1;
            bus.abort = 1'b1;
            @(posedge clk); #1;
            bus.abort = 1'b0;
            check("abort_done", {30'd0, bus.done, bus.aborted}, 32'd3);
            check("abort_sr_q", 32'(bus.sr_q), 32'h3);
            @(posedge clk); #1;
            check("abort_after", {29'd0, bus.done, bus.aborted, bus.cmd_ready}, 32'd1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
